// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, defaults, action encoding, adder.
// The optional FETCH_PERF_EN build adds performance counters in the interface and top.
package fetch_stage_pkg;

    localparam int          ADDR_W           = 32;
    localparam logic [31:0] PC_INCR          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_INSN = 32'h0000_0000;
    localparam logic [31:0] ALIGN_MASK       = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ACT_ADVANCE  = 2'd0,
        ACT_STALL    = 2'd1,
        ACT_REDIRECT = 2'd2
    } fetch_action_e;

    typedef struct packed {
        logic              v;
        logic [ADDR_W-1:0] pc;
    } inflight_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] pc4;
        logic [31:0]       insn;
    } ifid_t;

    // 32-bit modular adder used for every PC increment
    function automatic logic [31:0] add32(input logic [31:0] a, input logic [31:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage boundary: instruction ROM port, execute redirect, decode stall and IF/ID outputs.
// With FETCH_PERF_EN defined the perf counter outputs are part of the bundle.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              stall;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              ifid_valid;
    logic [ADDR_W-1:0] ifid_pc;
    logic [ADDR_W-1:0] ifid_pc_plus_4;
    logic [31:0]       ifid_insn;

`ifdef FETCH_PERF_EN
    logic [31:0]       perf_fetched;
    logic [31:0]       perf_stalls;

    modport master (
        output imem_addr, ifid_valid, ifid_pc, ifid_pc_plus_4, ifid_insn, perf_fetched, perf_stalls,
        input  imem_rdata, stall, redirect_valid, redirect_pc
    );
    modport slave (
        input  imem_addr, ifid_valid, ifid_pc, ifid_pc_plus_4, ifid_insn, perf_fetched, perf_stalls,
        output imem_rdata, stall, redirect_valid, redirect_pc
    );
`else
    modport master (
        output imem_addr, ifid_valid, ifid_pc, ifid_pc_plus_4, ifid_insn,
        input  imem_rdata, stall, redirect_valid, redirect_pc
    );
    modport slave (
        input  imem_addr, ifid_valid, ifid_pc, ifid_pc_plus_4, ifid_insn,
        output imem_rdata, stall, redirect_valid, redirect_pc
    );
`endif

endinterface

// File: rtl/fetch_hold_reg.sv
// One-entry capture register holding the in-flight ROM word while decode is stalled.
// Clear has priority over capture.
module fetch_hold_reg
    import fetch_stage_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              capture,
    input  logic              clear,
    input  logic [31:0]       d,
    output logic              hold_v,
    output logic [31:0]       hold_insn
);

    logic        hold_v_r;
    logic [31:0] hold_insn_r;

    // Capture / clear storage for the held word
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_v_r    <= 1'b0;
            hold_insn_r <= 32'd0;
        end else if (clear) begin
            hold_v_r    <= 1'b0;
        end else if (capture) begin
            hold_v_r    <= 1'b1;
            hold_insn_r <= d;
        end else begin
            hold_v_r    <= hold_v_r;
            hold_insn_r <= hold_insn_r;
        end
    end

    assign hold_v    = hold_v_r;
    assign hold_insn = hold_insn_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, tracks the in-flight ROM read and loads IF/ID.
// Optional feature macro: FETCH_PERF_EN (fetched / stall performance counters).
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSN = DEFAULT_NOP_INSN
) (
    input  logic          clock,
    input  logic          reset,
    fetch_stage_if.master bus
);

    logic [ADDR_W-1:0] pc_r;
    inflight_t         inflight_r;
    ifid_t             ifid_r;
    fetch_action_e     action_s;
    logic              hold_v_s;
    logic [31:0]       hold_insn_s;
    logic              hold_capture_s;
    logic              hold_clear_s;
    logic [ADDR_W-1:0] next_pc_s;
    logic [ADDR_W-1:0] inflight_pc4_s;
    logic [ADDR_W-1:0] redirect_target_s;
    logic [31:0]       fetch_insn_s;

    assign next_pc_s         = add32(pc_r, PC_INCR);
    assign inflight_pc4_s    = add32(inflight_r.pc, PC_INCR);
    assign redirect_target_s = bus.redirect_pc & ALIGN_MASK;

    // Per-cycle action: redirect beats stall beats advance
    always_comb begin
        action_s = ACT_ADVANCE;
        if (bus.redirect_valid) begin
            action_s = ACT_REDIRECT;
        end else if (bus.stall) begin
            action_s = ACT_STALL;
        end else begin
            action_s = ACT_ADVANCE;
        end
    end

    // Hold-register controls: grab the in-flight word once per stall, drop it otherwise
    always_comb begin
        hold_capture_s = 1'b0;
        hold_clear_s   = 1'b0;
        case (action_s)
            ACT_ADVANCE:  hold_clear_s   = 1'b1;
            ACT_STALL:    hold_capture_s = ~hold_v_s;
            ACT_REDIRECT: hold_clear_s   = 1'b1;
            default:      hold_clear_s   = 1'b1;
        endcase
    end

    // Word delivered to IF/ID on advance; a squashed slot carries NOP
    always_comb begin
        fetch_insn_s = NOP_INSN;
        if (!inflight_r.v) begin
            fetch_insn_s = NOP_INSN;
        end else if (hold_v_s) begin
            fetch_insn_s = hold_insn_s;
        end else begin
            fetch_insn_s = bus.imem_rdata;
        end
    end

    fetch_hold_reg u_hold (
        .clock     (clock),
        .reset     (reset),
        .capture   (hold_capture_s),
        .clear     (hold_clear_s),
        .d         (bus.imem_rdata),
        .hold_v    (hold_v_s),
        .hold_insn (hold_insn_s)
    );

    // PC, in-flight tracker and IF/ID pipeline register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_r       <= RESET_PC;
            inflight_r <= '{v: 1'b0, pc: 32'd0};
            ifid_r     <= '{valid: 1'b0, pc: 32'd0, pc4: 32'd0, insn: NOP_INSN};
        end else begin
            case (action_s)
                ACT_REDIRECT: begin
                    pc_r         <= redirect_target_s;
                    inflight_r.v <= 1'b0;
                    ifid_r.valid <= 1'b0;
                    ifid_r.insn  <= NOP_INSN;
                end
                ACT_STALL: begin
                    pc_r       <= pc_r;
                    inflight_r <= inflight_r;
                    ifid_r     <= ifid_r;
                end
                ACT_ADVANCE: begin
                    pc_r       <= next_pc_s;
                    inflight_r <= '{v: 1'b1, pc: pc_r};
                    ifid_r     <= '{valid: inflight_r.v, pc: inflight_r.pc,
                                    pc4: inflight_pc4_s, insn: fetch_insn_s};
                end
                default: begin
                    pc_r       <= pc_r;
                    inflight_r <= inflight_r;
                    ifid_r     <= ifid_r;
                end
            endcase
        end
    end

    assign bus.imem_addr      = pc_r;
    assign bus.ifid_valid     = ifid_r.valid;
    assign bus.ifid_pc        = ifid_r.pc;
    assign bus.ifid_pc_plus_4 = ifid_r.pc4;
    assign bus.ifid_insn      = ifid_r.insn;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_r;
    logic [31:0] perf_stalls_r;

    // Delivered-instruction and stall-cycle counters, wrapping at 2^32
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_fetched_r <= 32'd0;
            perf_stalls_r  <= 32'd0;
        end else begin
            if (action_s == ACT_ADVANCE && inflight_r.v) begin
                perf_fetched_r <= perf_fetched_r + 32'd1;
            end
            if (action_s == ACT_STALL) begin
                perf_stalls_r <= perf_stalls_r + 32'd1;
            end
        end
    end

    assign bus.perf_fetched = perf_fetched_r;
    assign bus.perf_stalls  = perf_stalls_r;
`endif

endmodule
